// File: rtl/decode_pipe.sv
// Single-entry instruction decode stage between fetch and execute.
// Optional load-use interlock and bubble counter enabled by DECODE_HAZARD_EN.
module decode_pipe #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [XLEN-1:0] f_inst,
  input  logic [XLEN-1:0] f_pc,
  input  logic            flush,
  output logic            e_valid,
  input  logic            e_ready,
  output logic [XLEN-1:0] e_pc,
  output logic [5:0]      e_opc,
  output logic [4:0]      e_ra,
  output logic [4:0]      e_rb,
  output logic [4:0]      e_rd,
  output logic [XLEN-1:0] e_imm,
  output logic [3:0]      e_alu_op,
  output logic            e_we,
  output logic            e_ld,
  output logic            e_str,
  output logic            e_brn,
  output logic            e_addi,
  output logic            e_illegal,
  output logic [CNTW-1:0] bubble_cnt
);

  localparam logic [5:0] OPC_ADD   = 6'd0;
  localparam logic [5:0] OPC_SUB   = 6'd1;
  localparam logic [5:0] OPC_AND   = 6'd2;
  localparam logic [5:0] OPC_OR    = 6'd3;
  localparam logic [5:0] OPC_XOR   = 6'd4;
  localparam logic [5:0] OPC_NOT   = 6'd5;
  localparam logic [5:0] OPC_SHL   = 6'd6;
  localparam logic [5:0] OPC_SHR   = 6'd7;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_LT    = 6'd9;
  localparam logic [5:0] OPC_GT    = 6'd10;
  localparam logic [5:0] OPC_LOAD  = 6'd11;
  localparam logic [5:0] OPC_STORE = 6'd12;
  localparam logic [5:0] OPC_CTRL  = 6'd13;

  localparam logic [4:0] SUB_JMP = 5'd0;
  localparam logic [4:0] SUB_BEQ = 5'd1;
  localparam logic [4:0] SUB_BLT = 5'd2;
  localparam logic [4:0] SUB_BGT = 5'd3;

  logic [5:0]      opc_s;
  logic [4:0]      ra_s;
  logic [4:0]      rb_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] imm_s;
  logic [3:0]      alu_op_s;
  logic            illegal_s;
  logic            we_s;
  logic            ld_s;
  logic            str_s;
  logic            brn_s;
  logic            addi_s;
  logic            hazard_s;
  logic            accept_s;

  assign opc_s = f_inst[31:26];
  assign ra_s  = f_inst[25:21];
  assign rb_s  = f_inst[20:16];
  assign rd_s  = f_inst[15:11];
  assign imm_s = {{(XLEN-11){f_inst[10]}}, f_inst[10:0]};

  // Opcode decode: ALU operation select and legality.
  always_comb begin
    alu_op_s  = 4'd0;
    illegal_s = 1'b0;
    case (opc_s)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_XOR, OPC_NOT, OPC_SHL, OPC_SHR: alu_op_s = opc_s[3:0];
      OPC_ADDI, OPC_LOAD, OPC_STORE:      alu_op_s = 4'd0;
      OPC_LT:                             alu_op_s = 4'd9;
      OPC_GT:                             alu_op_s = 4'd10;
      OPC_CTRL: begin
        case (rd_s)
          SUB_JMP, SUB_BEQ: alu_op_s  = 4'd0;
          SUB_BLT:          alu_op_s  = 4'd9;
          SUB_BGT:          alu_op_s  = 4'd10;
          default:          illegal_s = 1'b1;
        endcase
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Side-effect flags are forced low for illegal encodings.
  assign we_s   = !illegal_s & (opc_s <= OPC_LOAD);
  assign ld_s   = !illegal_s & (opc_s == OPC_LOAD);
  assign str_s  = !illegal_s & (opc_s == OPC_STORE);
  assign brn_s  = !illegal_s & (opc_s == OPC_CTRL);
  assign addi_s = !illegal_s & (opc_s == OPC_ADDI);

`ifdef DECODE_HAZARD_EN
  logic uses_rb_s;

  // Load-use detection against the entry currently held for execute.
  always_comb begin
    uses_rb_s = 1'b0;
    case (opc_s)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
      OPC_SHL, OPC_SHR, OPC_LT, OPC_GT, OPC_STORE: uses_rb_s = 1'b1;
      OPC_CTRL: uses_rb_s = (rd_s >= SUB_BEQ) & (rd_s <= SUB_BGT);
      default:  uses_rb_s = 1'b0;
    endcase
    hazard_s = f_valid & e_valid & e_ld &
               ((e_rd == ra_s) | (uses_rb_s & (e_rd == rb_s)));
  end

  // Saturating count of cycles stalled by the interlock while execute could drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= {CNTW{1'b0}};
    end else if (f_valid & (!e_valid | e_ready) & hazard_s &
                 (bubble_cnt != {CNTW{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end
`else
  assign hazard_s = 1'b0;

  // Interlock absent: counter stays at zero.
  always_ff @(posedge clk) begin
    bubble_cnt <= {CNTW{1'b0}};
  end
`endif

  assign f_ready  = !rst & (!e_valid | e_ready) & !hazard_s & !flush;
  assign accept_s = f_valid & f_ready;

  // Execute-side holding register; fields persist when valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid   <= 1'b0;
      e_pc      <= {XLEN{1'b0}};
      e_opc     <= 6'd0;
      e_ra      <= 5'd0;
      e_rb      <= 5'd0;
      e_rd      <= 5'd0;
      e_imm     <= {XLEN{1'b0}};
      e_alu_op  <= 4'd0;
      e_we      <= 1'b0;
      e_ld      <= 1'b0;
      e_str     <= 1'b0;
      e_brn     <= 1'b0;
      e_addi    <= 1'b0;
      e_illegal <= 1'b0;
    end else if (accept_s) begin
      e_valid   <= 1'b1;
      e_pc      <= f_pc;
      e_opc     <= opc_s;
      e_ra      <= ra_s;
      e_rb      <= rb_s;
      e_rd      <= rd_s;
      e_imm     <= imm_s;
      e_alu_op  <= alu_op_s;
      e_we      <= we_s;
      e_ld      <= ld_s;
      e_str     <= str_s;
      e_brn     <= brn_s;
      e_addi    <= addi_s;
      e_illegal <= illegal_s;
    end else if (flush | e_ready) begin
      e_valid   <= 1'b0;
    end else begin
      e_valid   <= e_valid;
    end
  end

endmodule
